// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin write arbiter in front of a register file.
// After reset (or on request) it zeroes every implemented register before granting writes.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [DATA_WIDTH-1:0] req0_data_i,
    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [DATA_WIDTH-1:0] req1_data_i,
    input  logic                  clear_i,
    output logic                  busy_o,
    output logic                  err_o,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(REG_COUNT - 1);
    // One bit wider so REG_COUNT == 2**ADDR_WIDTH does not wrap to zero.
    localparam logic [ADDR_WIDTH:0]   REG_LIMIT = (ADDR_WIDTH + 1)'(REG_COUNT);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    ptr_q, ptr_d;
    logic                    we_q, we_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic                    run_open;
    logic                    grant0;
    logic                    grant1;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_in_range;

    // Grant decode: a pending clear blocks both requesters for the whole cycle.
    always_comb begin
        run_open     = (state_q == ST_RUN) && !clear_i;
        grant0       = run_open && req0_valid_i && (!req1_valid_i || !ptr_q);
        grant1       = run_open && req1_valid_i && (!req0_valid_i || ptr_q);
        sel_addr     = grant1 ? req1_addr_i : req0_addr_i;
        sel_data     = grant1 ? req1_data_i : req0_data_i;
        sel_in_range = ({1'b0, sel_addr} < REG_LIMIT);
    end

    // Next-state and next-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        err_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_CLEAR: begin
                we_d    = 1'b1;
                waddr_d = cnt_q;
                wdata_d = {DATA_WIDTH{1'b0}};
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    cnt_d   = {ADDR_WIDTH{1'b0}};
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_RUN: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {ADDR_WIDTH{1'b0}};
                end else if (grant0 || grant1) begin
                    ptr_d = grant0;
                    if (sel_in_range) begin
                        we_d    = 1'b1;
                        waddr_d = sel_addr;
                        wdata_d = sel_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    ptr_d = ptr_q;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= {ADDR_WIDTH{1'b0}};
            ptr_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            waddr_q <= {ADDR_WIDTH{1'b0}};
            wdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            err_q   <= err_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy_o       = (state_q == ST_CLEAR);
    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;
    assign rf_we_o      = we_q;
    assign err_o        = err_q;
    assign rf_waddr_o   = waddr_q;
    assign rf_wdata_o   = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter; two instances (REG_COUNT 32 and 20)
// share the same stimulus and are each compared against a behavioural model.
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic v0 = 1'b0, v1 = 1'b0, clr = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;

    logic rdy0_a, rdy1_a, busy_a, err_a, we_a;
    logic [AW-1:0] waddr_a;
    logic [DW-1:0] wdata_a;
    logic rdy0_b, rdy1_b, busy_b, err_b, we_b;
    logic [AW-1:0] waddr_b;
    logic [DW-1:0] wdata_b;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state, one slot per instance.
    int          rc[2] = '{32, 20};
    bit          clearing[2];
    int          clr_next[2];
    int          pref[2];
    bit          e_we[2];
    bit          e_err[2];
    int          e_waddr[2];
    logic [31:0] e_wdata[2];
    bit          g0_e[2];
    bit          g1_e[2];

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(32)) u_dut_a (
        .clk_i(clk), .rst_i(rst_i),
        .req0_valid_i(v0), .req0_ready_o(rdy0_a), .req0_addr_i(a0), .req0_data_i(d0),
        .req1_valid_i(v1), .req1_ready_o(rdy1_a), .req1_addr_i(a1), .req1_data_i(d1),
        .clear_i(clr), .busy_o(busy_a), .err_o(err_a),
        .rf_we_o(we_a), .rf_waddr_o(waddr_a), .rf_wdata_o(wdata_a)
    );

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(20)) u_dut_b (
        .clk_i(clk), .rst_i(rst_i),
        .req0_valid_i(v0), .req0_ready_o(rdy0_b), .req0_addr_i(a0), .req0_data_i(d0),
        .req1_valid_i(v1), .req1_ready_o(rdy1_b), .req1_addr_i(a1), .req1_data_i(d1),
        .clear_i(clr), .busy_o(busy_b), .err_o(err_b),
        .rf_we_o(we_b), .rf_waddr_o(waddr_b), .rf_wdata_o(wdata_b)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            clearing[m] = 1'b1;
            clr_next[m] = 0;
            pref[m]     = 0;
            e_we[m]     = 1'b0;
            e_err[m]    = 1'b0;
            e_waddr[m]  = 0;
            e_wdata[m]  = 32'h0;
        end
    endtask

    // Expected grants follow directly from the round-robin rule on the current inputs.
    task automatic compute_grants();
        for (int m = 0; m < 2; m++) begin
            bit open;
            open    = !clearing[m] && !clr && !rst_i;
            g0_e[m] = open && v0 && (!v1 || pref[m] == 0);
            g1_e[m] = open && v1 && (!v0 || pref[m] == 1);
        end
    endtask

    task automatic check_inst(input int m, input string nm, input logic rdy0, input logic rdy1,
                              input logic busy, input logic err, input logic we,
                              input logic [AW-1:0] waddr, input logic [DW-1:0] wdata);
        check_val({nm, ".rdy0"}, 64'(rdy0), 64'(g0_e[m]));
        check_val({nm, ".rdy1"}, 64'(rdy1), 64'(g1_e[m]));
        check_val({nm, ".busy"}, 64'(busy), 64'(clearing[m]));
        check_val({nm, ".err"}, 64'(err), 64'(e_err[m]));
        check_val({nm, ".we"}, 64'(we), 64'(e_we[m]));
        check_val({nm, ".waddr"}, 64'(waddr), 64'(e_waddr[m]));
        check_val({nm, ".wdata"}, 64'(wdata), 64'(e_wdata[m]));
    endtask

    task automatic check_all();
        compute_grants();
        check_inst(0, "u_a", rdy0_a, rdy1_a, busy_a, err_a, we_a, waddr_a, wdata_a);
        check_inst(1, "u_b", rdy0_b, rdy1_b, busy_b, err_b, we_b, waddr_b, wdata_b);
    endtask

    // What each instance must show after the coming rising edge.
    task automatic model_advance();
        for (int m = 0; m < 2; m++) begin
            e_err[m] = 1'b0;
            e_we[m]  = 1'b0;
            if (clearing[m]) begin
                e_we[m]    = 1'b1;
                e_waddr[m] = clr_next[m];
                e_wdata[m] = 32'h0;
                clr_next[m]++;
                if (clr_next[m] == rc[m]) clearing[m] = 1'b0;
            end else if (clr) begin
                clearing[m] = 1'b1;
                clr_next[m] = 0;
            end else if (g0_e[m] || g1_e[m]) begin
                int k;
                int addr;
                k       = g0_e[m] ? 0 : 1;
                addr    = (k == 0) ? int'(a0) : int'(a1);
                pref[m] = 1 - k;
                if (addr < rc[m]) begin
                    e_we[m]    = 1'b1;
                    e_waddr[m] = addr;
                    e_wdata[m] = (k == 0) ? d0 : d1;
                end else begin
                    e_err[m] = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle(input logic iv0, input logic [AW-1:0] ia0, input logic [DW-1:0] id0,
                         input logic iv1, input logic [AW-1:0] ia1, input logic [DW-1:0] id1,
                         input logic iclr);
        @(negedge clk);
        v0 = iv0; a0 = ia0; d0 = id0;
        v1 = iv1; a1 = ia1; d1 = id1;
        clr = iclr;
        #1;
        check_all();
        model_advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    // Reset is asserted between edges and checked before any clock edge occurs.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #2 rst_i = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Full clear after reset: 32 writes on instance a, 20 on instance b.
        for (int i = 0; i < 34; i++) cycle(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 1'b0);
        idle(1);

        // Contention with pointer at 0: grants alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0);
        idle(1);

        // Single requester write.
        cycle(1'b1, 5'd3, 32'hCAFEBABE, 1'b0, 5'd0, 32'h0, 1'b0);
        idle(1);

        // Clear beats a pending req1; req1 held valid through the clear.
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b1);
        for (int i = 0; i < 34; i++) cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0);
        idle(1);

        // Out-of-range on the 20-register instance, in-range on the 32-register one.
        cycle(1'b1, 5'd25, 32'h5, 1'b0, 5'd0, 32'h0, 1'b0);
        idle(2);

        // Reset in the middle of a clear sequence.
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        idle(10);
        do_reset();
        idle(34);

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom),
                      1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom),
                      1'($urandom_range(0, 59) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
